// File: rtl/bp_pkg.sv
// Shared types, encodings and counter helper for the bimodal PHT controller.
package bp_pkg;

    localparam int ADDR_WIDTH_DEF = 5;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        INIT,
        DRAIN,
        IDLE,
        RD
    } pht_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] idx;
        logic                      taken;
    } upd_entry_t;

    // Saturating 2-bit counter step; never wraps past SNT or ST.
    function automatic logic [1:0] sat_update(input logic [1:0] c,
                                              input logic       taken);
        logic [1:0] n;
        n = c;
        if (taken) begin
            if (c != ST) n = c + 2'd1;
        end else begin
            if (c != SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO holding pending PHT updates, with registered full/empty.
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + (PW+1)'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - (PW+1)'(1);
        full_d  = (cnt_d == (PW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/bp_pht_ctrl.sv
// Dual-port PHT controller: port 0 serves lookups, port 1 does init and
// read-modify-write counter updates, with write-to-lookup forwarding.
module bp_pht_ctrl
    import bp_pkg::*;
#(
    parameter int         ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int         UPD_DEPTH  = 4,
    parameter logic [1:0] INIT_VAL   = WNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_req_valid,
    input  logic [31:0]           pred_pc,
    output logic                  pred_ready,
    output logic                  pred_resp_valid,
    output logic                  pred_taken,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    output logic                  init_done,
    output logic                  sram0_csb,
    output logic                  sram0_web,
    output logic [ADDR_WIDTH-1:0] sram0_addr,
    output logic [1:0]            sram0_din,
    input  logic [1:0]            sram0_dout,
    output logic                  sram1_csb,
    output logic                  sram1_web,
    output logic [ADDR_WIDTH-1:0] sram1_addr,
    output logic [1:0]            sram1_din,
    input  logic [1:0]            sram1_dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int EW    = ADDR_WIDTH + 1;

    pht_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  fwd_hit_q, fwd_hit_d;
    logic [1:0]            fwd_data_q, fwd_data_d;

    logic                  fifo_push, fifo_pop;
    logic                  fifo_full, fifo_empty;
    logic [EW-1:0]         fifo_din, fifo_dout;
    logic [ADDR_WIDTH-1:0] pred_idx, head_idx;
    logic                  head_taken, pred_acc;
    logic                  unused_bits;

    assign pred_idx   = pred_pc[ADDR_WIDTH+1:2];
    assign pred_ready = init_done_q;
    assign pred_acc   = pred_req_valid & init_done_q;

    assign sram0_csb  = ~pred_acc;
    assign sram0_web  = 1'b1;
    assign sram0_addr = pred_idx;
    assign sram0_din  = 2'b00;

    assign upd_ready  = init_done_q & ~fifo_full;
    assign fifo_push  = upd_valid & upd_ready;
    assign fifo_din   = {upd_pc[ADDR_WIDTH+1:2], upd_taken};
    assign head_idx   = fifo_dout[EW-1:1];
    assign head_taken = fifo_dout[0];

    assign unused_bits = ^{pred_pc[31:ADDR_WIDTH+2], pred_pc[1:0],
                           upd_pc[31:ADDR_WIDTH+2], upd_pc[1:0],
                           sram0_dout[0]};

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        sram1_csb   = 1'b1;
        sram1_web   = 1'b1;
        sram1_addr  = '0;
        sram1_din   = 2'b00;
        fifo_pop    = 1'b0;
        // Reset must silence port 1 at once, even mid-update.
        if (!rst) begin
            unique case (state_q)
                INIT: begin
                    sram1_csb  = 1'b0;
                    sram1_web  = 1'b0;
                    sram1_addr = init_cnt_q;
                    sram1_din  = INIT_VAL;
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                    if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = DRAIN;
                end
                DRAIN: begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
                IDLE: begin
                    if (!fifo_empty) begin
                        sram1_csb  = 1'b0;
                        sram1_addr = head_idx;
                        state_d    = RD;
                    end
                end
                RD: begin
                    sram1_csb  = 1'b0;
                    sram1_web  = 1'b0;
                    sram1_addr = head_idx;
                    sram1_din  = sat_update(sram1_dout, head_taken);
                    fifo_pop   = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = INIT;
            endcase
        end
    end

    // A lookup captured on the same edge as a port-1 write reads stale data.
    always_comb begin
        resp_valid_d = pred_acc;
        fwd_hit_d    = pred_acc & ~sram1_csb & ~sram1_web &
                       (sram1_addr == pred_idx);
        fwd_data_d   = sram1_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= resp_valid_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    assign init_done       = init_done_q;
    assign pred_resp_valid = resp_valid_q;
    assign pred_taken      = fwd_hit_q ? fwd_data_q[1] : sram0_dout[1];

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Scoreboard bench for bp_pht_ctrl with a behavioural dual-port PHT SRAM.
module tb_bp_pht_ctrl;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_req_valid, pred_ready, pred_resp_valid, pred_taken;
    logic [31:0] pred_pc, upd_pc;
    logic        upd_valid, upd_taken, upd_ready, init_done;
    logic        sram0_csb, sram0_web, sram1_csb, sram1_web;
    logic [4:0]  sram0_addr, sram1_addr;
    logic [1:0]  sram0_din, sram0_dout, sram1_din, sram1_dout;

    bp_pht_ctrl #(
        .ADDR_WIDTH (5),
        .UPD_DEPTH  (4),
        .INIT_VAL   (2'b01)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_req_valid  (pred_req_valid),
        .pred_pc         (pred_pc),
        .pred_ready      (pred_ready),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_ready       (upd_ready),
        .init_done       (init_done),
        .sram0_csb       (sram0_csb),
        .sram0_web       (sram0_web),
        .sram0_addr      (sram0_addr),
        .sram0_din       (sram0_din),
        .sram0_dout      (sram0_dout),
        .sram1_csb       (sram1_csb),
        .sram1_web       (sram1_web),
        .sram1_addr      (sram1_addr),
        .sram1_din       (sram1_din),
        .sram1_dout      (sram1_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: a write captured at E commits at E+1; a read at E+1 sees it.
    logic [1:0] mem [32];
    logic       wpend = 1'b0;
    logic [4:0] wa = '0;
    logic [1:0] wd = '0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 2'b11;
        sram0_dout = 2'b00;
        sram1_dout = 2'b00;
    end

    always @(posedge clk) begin
        if (wpend) mem[wa] <= wd;
        wpend <= !sram1_csb && !sram1_web;
        wa    <= sram1_addr;
        wd    <= sram1_din;
        if (!sram1_csb && sram1_web)
            sram1_dout <= (wpend && wa == sram1_addr) ? wd : mem[sram1_addr];
        if (!sram0_csb && sram0_web)
            sram0_dout <= (wpend && wa == sram0_addr) ? wd : mem[sram0_addr];
    end

    typedef struct packed {
        logic [4:0] a;
        logic [1:0] d;
    } wr_t;

    logic exp_pred_q [$];
    wr_t  exp_wr_q   [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (pred_resp_valid) begin
            if (exp_pred_q.size() == 0) fail_now("unexpected pred_resp");
            else check("pred_taken", pred_taken, exp_pred_q.pop_front());
        end
        if (!sram1_csb && !sram1_web) begin
            if (exp_wr_q.size() == 0) begin
                fail_now("unexpected port1 write");
            end else begin
                wr_t w;
                w = exp_wr_q.pop_front();
                check("p1_waddr", sram1_addr, w.a);
                check("p1_wdata", sram1_din, w.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int idx, input logic exp);
        check("pred_ready", pred_ready, 1);
        pred_req_valid = 1'b1;
        pred_pc        = 32'(idx) << 2;
        exp_pred_q.push_back(exp);
        tick();
    endtask

    task automatic upd(input int idx, input logic tk, input logic [1:0] wexp,
                       input logic expect_wr, output int waits);
        wr_t w;
        upd_valid = 1'b1;
        upd_pc    = 32'(idx) << 2;
        upd_taken = tk;
        waits     = 0;
        while (!upd_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!upd_ready) begin
            fail_now("upd_ready timeout");
        end else if (expect_wr) begin
            w.a = 5'(idx);
            w.d = wexp;
            exp_wr_q.push_back(w);
        end
        tick();
    endtask

    task automatic expect_init();
        wr_t w;
        for (int k = 0; k < 32; k++) begin
            w.a = 5'(k);
            w.d = WNT;
            exp_wr_q.push_back(w);
        end
    endtask

    int         w;
    int         f_idx [8] = '{8, 9, 8, 9, 8, 10, 10, 9};
    logic       f_tk  [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
    logic [1:0] f_exp [8] = '{WT, SNT, ST, SNT, ST, WT, ST, WNT};
    int         f_wt  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic [1:0] s_up  [4] = '{WT, ST, ST, ST};
    logic [1:0] s_dn  [4] = '{WT, WNT, SNT, SNT};

    initial begin
        pred_req_valid = 1'b0;
        pred_pc        = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst pred_resp_valid", pred_resp_valid, 0);
        check("rst init_done", init_done, 0);
        check("rst pred_ready", pred_ready, 0);
        check("rst upd_ready", upd_ready, 0);
        check("rst sram0_csb", sram0_csb, 1);
        check("rst sram1_csb", sram1_csb, 1);
        check("rst sram0_web", sram0_web, 1);
        check("rst sram1_web", sram1_web, 1);

        expect_init();
        rst = 1'b0;
        repeat (32) tick();
        check("drain init_done", init_done, 0);
        check("drain pred_ready", pred_ready, 0);
        check("drain upd_ready", upd_ready, 0);
        tick();
        check("init_done", init_done, 1);
        check("ready after init", upd_ready, 1);

        lookup(4, 1'b0);
        pred_req_valid = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 4; i++) begin
            upd(4, 1'b1, s_up[i], 1'b1, w);
            upd_valid = 1'b0;
            repeat (3) tick();
        end
        lookup(4, 1'b1);
        pred_req_valid = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            upd(4, 1'b0, s_dn[i], 1'b1, w);
            upd_valid = 1'b0;
            repeat (3) tick();
        end
        lookup(4, 1'b0);
        pred_req_valid = 1'b0;
        repeat (4) tick();

        // Lookup lands on the write-issue edge, then once more after commit.
        upd(7, 1'b1, WT, 1'b1, w);
        upd_valid = 1'b0;
        tick();
        lookup(7, 1'b1);
        lookup(7, 1'b1);
        pred_req_valid = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) begin
            upd(f_idx[i], f_tk[i], f_exp[i], 1'b1, w);
            check("fifo wait cycles", w, f_wt[i]);
        end
        upd_valid = 1'b0;
        repeat (20) tick();
        lookup(8, 1'b1);
        lookup(9, 1'b0);
        lookup(10, 1'b1);
        pred_req_valid = 1'b0;
        repeat (4) tick();

        upd(20, 1'b1, WT, 1'b1, w);
        upd(21, 1'b1, WT, 1'b0, w);
        upd(22, 1'b1, WT, 1'b0, w);
        upd(23, 1'b1, WT, 1'b0, w);
        upd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst sram1_csb", sram1_csb, 1);
        check("midrst init_done", init_done, 0);
        check("midrst upd_ready", upd_ready, 0);
        expect_init();
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("reinit init_done", init_done, 1);
        lookup(20, 1'b0);
        lookup(21, 1'b0);
        lookup(22, 1'b0);
        lookup(8, 1'b0);
        pred_req_valid = 1'b0;
        repeat (6) tick();

        check("pred queue drained", exp_pred_q.size(), 0);
        check("write queue drained", exp_wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
